round_key_bank: RTL

//  Parametrised round-key store: holds up to NUM_KEYS round keys, loaded one per cycle by the key expander.

---
 rtl/round_key_bank_if.sv | 31 +++
 rtl/round_key_bank.sv | 111 +++++++++++
 2 files changed

// File: rtl/round_key_bank_if.sv
// Bundles the key-expander load port, the round-key read ports and the status outputs.
// Master drives loads and reads; slave is the key bank.
interface round_key_bank_if #(
    parameter int KEY_W     = 128,
    parameter int NUM_KEYS  = 15,
    parameter int NUM_PORTS = 3
);
    localparam int IDX_W = $clog2(NUM_KEYS);

    logic                       clear;
    logic [IDX_W-1:0]           cfg_last_idx;
    logic                       load;
    logic [IDX_W-1:0]           load_idx;
    logic [KEY_W-1:0]           load_key;
    logic                       load_err;
    logic                       encrypt_flag;
    logic [NUM_PORTS*IDX_W-1:0] rd_idx;
    logic [NUM_PORTS*KEY_W-1:0] rd_key;
    logic [NUM_PORTS-1:0]       rd_valid;
    logic                       sched_ready;

    modport master (
        output clear, cfg_last_idx, load, load_idx, load_key, encrypt_flag, rd_idx,
        input  load_err, rd_key, rd_valid, sched_ready
    );

    modport slave (
        input  clear, cfg_last_idx, load, load_idx, load_key, encrypt_flag, rd_idx,
        output load_err, rd_key, rd_valid, sched_ready
    );
endinterface

// File: rtl/round_key_bank.sv
// Round-key store with per-slot valid bits, a latched schedule length and N independent read ports.
// Reads are registered (1 cycle, write-first bypass); no backpressure, rejected loads pulse load_err.
module round_key_bank #(
    parameter int KEY_W     = 128,
    parameter int NUM_KEYS  = 15,
    parameter int NUM_PORTS = 3
) (
    input  logic              clk,
    input  logic              rst,
    round_key_bank_if.slave   bus
);
    localparam int               IDX_W   = $clog2(NUM_KEYS);
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NUM_KEYS - 1);

    typedef enum logic [1:0] {EMPTY, FILLING, READY} state_t;

    state_t                     state_q, state_d;
    logic [KEY_W-1:0]           slot_q [NUM_KEYS];
    logic [KEY_W-1:0]           slot_d [NUM_KEYS];
    logic [NUM_KEYS-1:0]        valid_q, valid_d;
    logic [IDX_W-1:0]           last_idx_q, last_idx_d;
    logic                       load_err_q, load_err_d;
    logic                       sched_ready_q, sched_ready_d;
    logic [NUM_PORTS*KEY_W-1:0] rd_key_q, rd_key_d;
    logic [NUM_PORTS-1:0]       rd_valid_q, rd_valid_d;

    logic [IDX_W-1:0]           cfg_clamped;
    logic [IDX_W-1:0]           load_lim;
    logic                       accept;
    logic                       complete;
    logic [IDX_W-1:0]           rd_raw [NUM_PORTS];
    logic [IDX_W-1:0]           rd_eff [NUM_PORTS];

    // Load acceptance, slot update and schedule state
    always_comb begin
        cfg_clamped = (bus.cfg_last_idx > MAX_IDX) ? MAX_IDX : bus.cfg_last_idx;
        load_lim    = (state_q == EMPTY) ? cfg_clamped : last_idx_q;
        accept      = bus.load && !bus.clear && (state_q != READY) && (bus.load_idx <= load_lim);
        load_err_d  = bus.load && !bus.clear && !accept;

        slot_d     = slot_q;
        valid_d    = valid_q;
        last_idx_d = last_idx_q;
        state_d    = state_q;

        if (bus.clear) begin
            for (int i = 0; i < NUM_KEYS; i++) slot_d[i] = '0;
            valid_d    = '0;
            last_idx_d = MAX_IDX;
            state_d    = EMPTY;
        end else if (accept) begin
            slot_d[bus.load_idx]  = bus.load_key;
            valid_d[bus.load_idx] = 1'b1;
            if (state_q == EMPTY) last_idx_d = cfg_clamped;
        end

        complete = 1'b1;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if ((IDX_W'(i) <= last_idx_d) && !valid_d[i]) complete = 1'b0;
        end
        if (accept) state_d = complete ? READY : FILLING;

        sched_ready_d = (state_d == READY);
    end

    // Read ports: index mapping uses the schedule length held this cycle
    always_comb begin
        rd_key_d   = '0;
        rd_valid_d = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rd_raw[p] = bus.rd_idx[p*IDX_W +: IDX_W];
            rd_eff[p] = bus.encrypt_flag ? rd_raw[p] : (last_idx_q - rd_raw[p]);
            if (!bus.clear && (rd_raw[p] <= last_idx_q)) begin
                if (accept && (bus.load_idx == rd_eff[p])) begin
                    rd_key_d[p*KEY_W +: KEY_W] = bus.load_key;
                    rd_valid_d[p]              = 1'b1;
                end else if (valid_q[rd_eff[p]]) begin
                    rd_key_d[p*KEY_W +: KEY_W] = slot_q[rd_eff[p]];
                    rd_valid_d[p]              = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            for (int i = 0; i < NUM_KEYS; i++) slot_q[i] <= '0;
            valid_q       <= '0;
            last_idx_q    <= MAX_IDX;
            load_err_q    <= 1'b0;
            sched_ready_q <= 1'b0;
            rd_key_q      <= '0;
            rd_valid_q    <= '0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            valid_q       <= valid_d;
            last_idx_q    <= last_idx_d;
            load_err_q    <= load_err_d;
            sched_ready_q <= sched_ready_d;
            rd_key_q      <= rd_key_d;
            rd_valid_q    <= rd_valid_d;
        end
    end

    assign bus.load_err    = load_err_q;
    assign bus.sched_ready = sched_ready_q;
    assign bus.rd_key      = rd_key_q;
    assign bus.rd_valid    = rd_valid_q;
endmodule
